// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button front end and the mode/adjust FSM.
// Both blocks import this package so that they agree on the bit order of
// the 5-bit button vector {U, D, L, R, C}.
//   BTN_U..BTN_C : bit index of each button inside the vector
//   BTN_W        : width of the button vector
//   btn_vec_t    : the button vector type
//   cntWidth     : bits needed for a counter that runs 0..maxCount-1
package button_conditioner_pkg;

  localparam int BTN_W = 5;
  localparam int BTN_U = 4;
  localparam int BTN_D = 3;
  localparam int BTN_L = 2;
  localparam int BTN_R = 1;
  localparam int BTN_C = 0;

  typedef logic [BTN_W-1:0] btn_vec_t;

  // A counter that only ever holds 0..maxCount-1 needs $clog2(maxCount)
  // bits, but never fewer than one so the register always exists.
  function automatic int cntWidth(input int maxCount);
    return (maxCount <= 1) ? 1 : $clog2(maxCount);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button's conditioning chain: 2-flop synchroniser, tick-gated
// debounce, rising-edge detect and optional auto-repeat.
//   clk_i   : board clock
//   rst_ni  : asynchronous active-low reset
//   tick_i  : sample strobe, one clk wide
//   raw_i   : raw (asynchronous) button input
//   level_o : debounced stable level
//   pulse_o : combinational press/repeat pulse, registered by the parent
module debounce_cell
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 100,
  parameter int REPEAT_PERIOD  = 25,
  parameter bit REPEAT_EN      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int DW = cntWidth(DEBOUNCE_TICKS);
  localparam int RW = cntWidth((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST   = RW'(REPEAT_PERIOD - 1);

  logic          syncFirst_q, syncSecond_q;
  logic          stable_q, stable_d;
  logic          stablePrev_q;
  logic [DW-1:0] dbCnt_q, dbCnt_d;
  logic [RW-1:0] repCnt_q, repCnt_d;
  logic          firstRep_q, firstRep_d;
  logic          rise;
  logic          repPulse;

  // Synchroniser runs every clock; the remaining state advances as computed
  // by the combinational blocks below.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      syncFirst_q  <= 1'b0;
      syncSecond_q <= 1'b0;
      stable_q     <= 1'b0;
      stablePrev_q <= 1'b0;
      dbCnt_q      <= '0;
      repCnt_q     <= '0;
      firstRep_q   <= 1'b0;
    end else begin
      syncFirst_q  <= raw_i;
      syncSecond_q <= syncFirst_q;
      stable_q     <= stable_d;
      stablePrev_q <= stable_q;
      dbCnt_q      <= dbCnt_d;
      repCnt_q     <= repCnt_d;
      firstRep_q   <= firstRep_d;
    end
  end

  // Debounce: the stable level flips only after DEBOUNCE_TICKS consecutive
  // ticks disagree with it; any agreeing tick restarts the count.
  always_comb begin
    stable_d = stable_q;
    dbCnt_d  = dbCnt_q;
    if (tick_i) begin
      if (syncSecond_q != stable_q) begin
        if (dbCnt_q == DB_LAST) begin
          stable_d = syncSecond_q;
          dbCnt_d  = '0;
        end else begin
          dbCnt_d = dbCnt_q + DW'(1);
        end
      end else begin
        dbCnt_d = '0;
      end
    end
  end

  assign rise = stable_q & ~stablePrev_q;

  // Auto-repeat: the press itself restarts the count, so the first repeat
  // lands REPEAT_DELAY ticks after the press pulse and later ones every
  // REPEAT_PERIOD ticks. The compare is tick-gated so a slow strobe cannot
  // fire the same count more than once.
  always_comb begin
    repCnt_d   = repCnt_q;
    firstRep_d = firstRep_q;
    repPulse   = 1'b0;
    if (!REPEAT_EN || !stable_q) begin
      repCnt_d   = '0;
      firstRep_d = 1'b0;
    end else if (rise) begin
      repCnt_d   = '0;
      firstRep_d = 1'b1;
    end else if (tick_i) begin
      if (firstRep_q && (repCnt_q == DELAY_LAST)) begin
        repPulse   = 1'b1;
        repCnt_d   = '0;
        firstRep_d = 1'b0;
      end else if (!firstRep_q && (repCnt_q == PER_LAST)) begin
        repPulse = 1'b1;
        repCnt_d = '0;
      end else begin
        repCnt_d = repCnt_q + RW'(1);
      end
    end
  end

  assign level_o = stable_q;
  assign pulse_o = rise | repPulse;

endmodule

// File: rtl/button_conditioner.sv
// Button front end for the mode/adjust FSM. Five debounce cells feed a
// fixed-priority arbiter (C > R > L > U > D) so the FSM only ever sees a
// zero or one-hot, single-cycle pulse.
//   clk           : board clock
//   reset         : asynchronous reset, active LOW despite the name
//   tick_en       : sample strobe from the clock divider, one clk wide
//   btn_raw       : raw buttons {U, D, L, R, C}
//   btn_pulse     : registered one-hot press/repeat pulse
//   btn_level     : debounced level per button
//   collision     : sticky, set when simultaneous pulses were dropped
//   clr_collision : synchronous clear for collision (a new collision wins)
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int         DEBOUNCE_TICKS = 4,
  parameter int         REPEAT_DELAY   = 100,
  parameter int         REPEAT_PERIOD  = 25,
  parameter logic [4:0] REPEAT_MASK    = 5'b11000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_en,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_pulse,
  output logic [4:0] btn_level,
  output logic       collision,
  input  logic       clr_collision
);

  btn_vec_t rawPulse;
  btn_vec_t grant;
  btn_vec_t btnPulse_q;
  logic     multiHit;
  logic     collision_q, collision_d;

  for (genvar i = 0; i < BTN_W; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .REPEAT_EN     (REPEAT_MASK[i])
    ) u_cell (
      .clk_i  (clk),
      .rst_ni (reset),
      .tick_i (tick_en),
      .raw_i  (btn_raw[i]),
      .level_o(btn_level[i]),
      .pulse_o(rawPulse[i])
    );
  end

  // Priority is not bit order: U outranks D even though D sits lower.
  always_comb begin
    grant = '0;
    if (rawPulse[BTN_C])      grant[BTN_C] = 1'b1;
    else if (rawPulse[BTN_R]) grant[BTN_R] = 1'b1;
    else if (rawPulse[BTN_L]) grant[BTN_L] = 1'b1;
    else if (rawPulse[BTN_U]) grant[BTN_U] = 1'b1;
    else if (rawPulse[BTN_D]) grant[BTN_D] = 1'b1;
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multiHit = |(rawPulse & (rawPulse - 5'd1));

  always_comb begin
    collision_d = collision_q;
    if (multiHit)           collision_d = 1'b1;
    else if (clr_collision) collision_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btnPulse_q  <= '0;
      collision_q <= 1'b0;
    end else begin
      btnPulse_q  <= grant;
      collision_q <= collision_d;
    end
  end

  assign btn_pulse = btnPulse_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DEBOUNCE_TICKS=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=3). A behavioural model compares every
// output on every cycle; hand sequences and an arbitration table add
// explicit cycle-exact checks.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int DEB  = 4;
  localparam int RDLY = 8;
  localparam int RPER = 3;
  localparam logic [4:0] MASK = 5'b11000;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       tickEn = 1'b0;
  logic       clrCol = 1'b0;
  logic [4:0] btnRaw = 5'b0;
  logic [4:0] btn_pulse;
  logic [4:0] btn_level;
  logic       collision;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_TICKS(DEB),
    .REPEAT_DELAY  (RDLY),
    .REPEAT_PERIOD (RPER),
    .REPEAT_MASK   (MASK)
  ) dut (
    .clk          (clk),
    .reset        (resetN),
    .tick_en      (tickEn),
    .btn_raw      (btnRaw),
    .btn_pulse    (btn_pulse),
    .btn_level    (btn_level),
    .collision    (collision),
    .clr_collision(clrCol)
  );

  // Behavioural reference: sync is a two-edge delay of the raw input, the
  // stable level flips once the last DEB tick samples all disagree with it,
  // and repeats are due at tick DELAY and every PERIOD ticks after the press.
  bit mStable[5];
  bit mRise[5];
  bit mS1[5];
  bit mS2[5];
  int mSince[5];
  int mWinCnt[5];
  bit mWin[5][DEB];
  logic [4:0] expPulse = 5'b0;
  logic [4:0] expLevel = 5'b0;
  logic       expCol = 1'b0;

  function automatic bit repeatDue(input int since);
    return (since == RDLY) || ((since > RDLY) && (((since - RDLY) % RPER) == 0));
  endfunction

  function automatic logic [4:0] pickWinner(input logic [4:0] rp);
    int ord[5];
    logic [4:0] w;
    bit found;
    ord = '{BTN_C, BTN_R, BTN_L, BTN_U, BTN_D};
    w = 5'b0;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (!found && rp[ord[k]]) begin
        w[ord[k]] = 1'b1;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  task automatic modelEdge(input logic [4:0] raw, input logic tick, input logic clr, input logic rstN);
    logic [4:0] rp;
    logic [4:0] maskV;
    bit newSt;
    bit allDiff;
    maskV = MASK;
    if (!rstN) begin
      for (int i = 0; i < 5; i++) begin
        mStable[i] = 0; mRise[i] = 0; mS1[i] = 0; mS2[i] = 0;
        mSince[i] = 0; mWinCnt[i] = 0;
        for (int k = 0; k < DEB; k++) mWin[i][k] = 0;
      end
      expPulse = 5'b0;
      expLevel = 5'b0;
      expCol = 1'b0;
      return;
    end
    rp = 5'b0;
    for (int i = 0; i < 5; i++) begin
      if (mRise[i]) begin
        rp[i] = 1'b1;
        mSince[i] = 0;
      end else if (mStable[i] && tick) begin
        mSince[i]++;
        if (maskV[i] && repeatDue(mSince[i])) rp[i] = 1'b1;
      end
    end
    expPulse = pickWinner(rp);
    if ($countones(rp) > 1) expCol = 1'b1;
    else if (clr) expCol = 1'b0;
    for (int i = 0; i < 5; i++) begin
      newSt = mStable[i];
      if (tick) begin
        for (int k = 0; k < DEB - 1; k++) mWin[i][k] = mWin[i][k+1];
        mWin[i][DEB-1] = mS2[i];
        if (mWinCnt[i] < DEB) mWinCnt[i]++;
        allDiff = (mWinCnt[i] == DEB);
        for (int k = 0; k < DEB; k++) if (mWin[i][k] == mStable[i]) allDiff = 1'b0;
        if (allDiff) newSt = !mStable[i];
      end
      mRise[i] = newSt && !mStable[i];
      mStable[i] = newSt;
      expLevel[i] = newSt;
      mS2[i] = mS1[i];
      mS1[i] = raw[i];
    end
  endtask

  task automatic checkOutput(input string name, input logic [4:0] actual, input logic [4:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, compare 1 time unit later.
  task automatic applyStimulus(input logic [4:0] raw, input logic tick, input logic clr, input logic rstN);
    btnRaw = raw;
    tickEn = tick;
    clrCol = clr;
    resetN = rstN;
    if (!rstN) begin
      #1;
      checkOutput("async reset pulse", btn_pulse, 5'b0);
      checkOutput("async reset level", btn_level, 5'b0);
      checkOutput("async reset collision", {4'b0, collision}, 5'b0);
    end
    @(posedge clk);
    modelEdge(raw, tick, clr, rstN);
    #1;
    checkOutput("model pulse", btn_pulse, expPulse);
    checkOutput("model level", btn_level, expLevel);
    checkOutput("model collision", {4'b0, collision}, {4'b0, expCol});
  endtask

  task automatic idle(input int n);
    for (int s = 0; s < n; s++) applyStimulus(5'b0, 1'b1, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic [4:0] press;
    logic [4:0] expPulse;
    logic       expCol;
  } arbVec_t;

  arbVec_t arbTable[8];

  initial begin
    int hits;
    int riseStep;
    int ticksSeen;
    bit tickAtRise;
    logic slowTick;
    logic [4:0] r;

    arbTable[0] = '{5'b00001, 5'b00001, 1'b0};
    arbTable[1] = '{5'b10001, 5'b00001, 1'b1};
    arbTable[2] = '{5'b00110, 5'b00010, 1'b1};
    arbTable[3] = '{5'b11000, 5'b10000, 1'b1};
    arbTable[4] = '{5'b00100, 5'b00100, 1'b0};
    arbTable[5] = '{5'b01000, 5'b01000, 1'b0};
    arbTable[6] = '{5'b11100, 5'b00100, 1'b1};
    arbTable[7] = '{5'b11111, 5'b00001, 1'b1};

    #2;
    for (int s = 0; s < 3; s++) applyStimulus(5'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset level", btn_level, 5'b0);
    checkOutput("reset pulse", btn_pulse, 5'b0);

    // Clean press on C, released after 20 cycles
    for (int s = 1; s <= 30; s++) begin
      applyStimulus((s <= 20) ? 5'b00001 : 5'b0, 1'b1, 1'b0, 1'b1);
      if (s == 5)  checkOutput("press level c5", btn_level, 5'b0);
      if (s == 6)  checkOutput("press level c6", btn_level, 5'b00001);
      if (s == 7)  checkOutput("press pulse c7", btn_pulse, 5'b00001);
      if (s == 6 || s == 8 || s > 20) checkOutput("press no pulse", btn_pulse, 5'b0);
      if (s == 25) checkOutput("release level c25", btn_level, 5'b00001);
      if (s == 26) checkOutput("release level c26", btn_level, 5'b0);
    end

    // Bounce rejection on L
    hits = 0;
    for (int s = 0; s < 40; s++) begin
      applyStimulus(((s % 4) != 3) ? 5'b00100 : 5'b0, 1'b1, 1'b0, 1'b1);
      if (btn_level != 5'b0 || btn_pulse != 5'b0) hits++;
    end
    checkOutput("bounce activity", 5'(hits), 5'b0);
    idle(10);

    // Auto-repeat on U
    for (int s = 1; s <= 30; s++) begin
      applyStimulus(5'b10000, 1'b1, 1'b0, 1'b1);
      checkOutput("repeat U",
                  btn_pulse,
                  (s == 7 || (s >= 15 && ((s - 15) % 3) == 0)) ? 5'b10000 : 5'b0);
    end
    idle(12);

    // C never repeats
    hits = 0;
    for (int s = 1; s <= 42; s++) begin
      applyStimulus((s <= 30) ? 5'b00001 : 5'b0, 1'b1, 1'b0, 1'b1);
      if (btn_pulse != 5'b0) hits++;
    end
    checkOutput("C single pulse", 5'(hits), 5'd1);
    idle(4);

    // Arbitration table
    for (int v = 0; v < 8; v++) begin
      idle(10);
      applyStimulus(5'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("collision cleared", {4'b0, collision}, 5'b0);
      for (int s = 1; s <= 7; s++) applyStimulus(arbTable[v].press, 1'b1, 1'b0, 1'b1);
      checkOutput("arb pulse", btn_pulse, arbTable[v].expPulse);
      checkOutput("arb collision", {4'b0, collision}, {4'b0, arbTable[v].expCol});
    end
    idle(10);

    // A new collision beats a simultaneous clear
    applyStimulus(5'b0, 1'b1, 1'b1, 1'b1);
    for (int s = 1; s <= 6; s++) applyStimulus(5'b10001, 1'b1, 1'b0, 1'b1);
    applyStimulus(5'b10001, 1'b1, 1'b1, 1'b1);
    checkOutput("set beats clear", {4'b0, collision}, 5'b00001);
    applyStimulus(5'b10001, 1'b1, 1'b1, 1'b1);
    checkOutput("clear after set", {4'b0, collision}, 5'b0);
    idle(12);

    // Slow strobe on D: level must rise on the 4th tick after sync
    riseStep = 0;
    ticksSeen = 0;
    tickAtRise = 1'b0;
    for (int s = 1; s <= 40; s++) begin
      slowTick = ((s % 4) == 0);
      applyStimulus(5'b01000, slowTick, 1'b0, 1'b1);
      if (s >= 3 && riseStep == 0 && slowTick) ticksSeen++;
      if (riseStep == 0 && btn_level[BTN_D]) begin
        riseStep = s;
        tickAtRise = slowTick;
      end
    end
    checkOutput("slow rise seen", 5'(riseStep != 0), 5'd1);
    checkOutput("slow rise on tick", {4'b0, tickAtRise}, 5'd1);
    checkOutput("slow ticks to rise", 5'(ticksSeen), 5'(DEB));
    for (int s = 1; s <= 30; s++) applyStimulus(5'b0, ((s % 4) == 0), 1'b0, 1'b1);
    idle(4);

    // tick_en held low: nothing moves
    hits = 0;
    for (int s = 0; s < 30; s++) begin
      applyStimulus(5'b10000, 1'b0, 1'b0, 1'b1);
      if (btn_level != 5'b0 || btn_pulse != 5'b0) hits++;
    end
    checkOutput("frozen activity", 5'(hits), 5'b0);
    for (int s = 0; s < 4; s++) applyStimulus(5'b0, 1'b0, 1'b0, 1'b1);
    idle(6);

    // Reset in the middle of a repeat, U still held afterwards
    for (int s = 1; s <= 40; s++) begin
      applyStimulus(5'b10000, 1'b1, 1'b0, !(s == 17 || s == 18));
      if (s == 16) checkOutput("pre-reset level", btn_level, 5'b10000);
      if (s >= 19 && s <= 34)
        checkOutput("post-reset pulse", btn_pulse, (s == 25 || s == 33) ? 5'b10000 : 5'b0);
    end
    idle(12);

    // Randomised traffic against the model
    r = 5'b0;
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 5) == 0) r = r ^ (5'b00001 << $urandom_range(0, 4));
      applyStimulus(r, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 149) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
